// File: rtl/boxcar_avg_filter.sv
// rtl/boxcar_avg_filter.sv - running-sum boxcar filter over the last TAPS accepted samples
module boxcar_avg_filter #(
    parameter int DATA_W    = 8,
    parameter int TAPS      = 8,
    localparam int LOG2_TAPS = $clog2(TAPS),
    localparam int SUM_W     = DATA_W + LOG2_TAPS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    output logic signed [SUM_W-1:0]  out_sum,
    output logic signed [DATA_W-1:0] out_avg,
    output logic                     out_full
);

    localparam int CNT_W = $clog2(TAPS + 1);

    logic signed [DATA_W-1:0] delay_line [TAPS];
    logic        [CNT_W-1:0]  fill;
    logic signed [SUM_W-1:0]  in_ext;
    logic signed [SUM_W-1:0]  old_ext;
    logic signed [SUM_W-1:0]  acc_next;

    // Unfilled slots hold zero, so evicting them leaves the partial sum exact.
    assign in_ext   = {{LOG2_TAPS{in_data[DATA_W-1]}}, in_data};
    assign old_ext  = {{LOG2_TAPS{delay_line[TAPS-1][DATA_W-1]}}, delay_line[TAPS-1]};
    assign acc_next = out_sum + in_ext - old_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) delay_line[i] <= '0;
            fill      <= '0;
            out_sum   <= '0;
            out_avg   <= '0;
            out_full  <= 1'b0;
            out_valid <= 1'b0;
        end else if (clr) begin
            for (int i = 0; i < TAPS; i++) delay_line[i] <= '0;
            fill      <= '0;
            out_sum   <= '0;
            out_avg   <= '0;
            out_full  <= 1'b0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            delay_line[0] <= in_data;
            for (int i = 1; i < TAPS; i++) delay_line[i] <= delay_line[i-1];
            out_sum   <= acc_next;
            // Dropping the low bits of a signed sum is a floor divide by TAPS.
            out_avg   <= acc_next[SUM_W-1:LOG2_TAPS];
            out_valid <= 1'b1;
            if (fill != CNT_W'(TAPS)) fill <= fill + 1'b1;
            out_full  <= out_full | (fill == CNT_W'(TAPS - 1));
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_boxcar_avg_filter.sv
// tb/tb_boxcar_avg_filter.sv - directed self-checking bench for boxcar_avg_filter
module tb_boxcar_avg_filter;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clr;
    logic              in_valid;
    logic signed [7:0] in_data;
    logic              out_valid;
    logic signed [10:0] out_sum;
    logic signed [7:0] out_avg;
    logic              out_full;

    int n_checks = 0;
    int n_fail   = 0;

    boxcar_avg_filter #(.DATA_W(8), .TAPS(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .in_valid (in_valid),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_sum  (out_sum),
        .out_avg  (out_avg),
        .out_full (out_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int d, input logic c);
        in_valid = v;
        in_data  = 8'(d);
        clr      = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int sum, input int avg,
                             input logic valid, input logic full);
        check({tag, ".sum"},   out_sum,   sum);
        check({tag, ".avg"},   out_avg,   avg);
        check({tag, ".valid"}, out_valid, valid);
        check({tag, ".full"},  out_full,  full);
    endtask

    initial begin
        int sum;
        int pulses;
        rst_n    = 1'b0;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset_init", 0, 0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // load some state, then reset between edges
        drive(1'b1, 10, 1'b0);
        drive(1'b1, 10, 1'b0);
        drive(1'b1, 10, 1'b0);
        check_all("pre_reset", 30, 3, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_all("async_reset", 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 0, 1'b0);
        check_all("post_reset_idle", 0, 0, 1'b0, 1'b0);

        // step: 9 x 10
        for (int i = 0; i < 9; i++) begin
            int exp_sum;
            drive(1'b1, 10, 1'b0);
            exp_sum = (i < 8) ? 10 * (i + 1) : 80;
            check_all($sformatf("step%0d", i), exp_sum, exp_sum >>> 3, 1'b1, i >= 7);
        end

        // extremes
        drive(1'b0, 0, 1'b1);
        check_all("clr_ext", 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, -128, 1'b0);
            check_all($sformatf("neg%0d", i), -128 * (i + 1), -16 * (i + 1), 1'b1, i >= 7);
        end
        sum = -1024;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 127, 1'b0);
            sum = sum + 255;
            check_all($sformatf("pos%0d", i), sum, sum >>> 3, 1'b1, 1'b1);
        end
        check("pos_final_sum", out_sum, 1016);
        check("pos_final_avg", out_avg, 127);

        // gaps: 5,_,_,7,_,9
        drive(1'b0, 0, 1'b1);
        pulses = 0;
        drive(1'b1, 5, 1'b0); pulses += out_valid; check("gap_s0", out_sum, 5);
        drive(1'b0, 0, 1'b0); pulses += out_valid; check("gap_s1", out_sum, 5);
        drive(1'b0, 0, 1'b0); pulses += out_valid; check("gap_s2", out_sum, 5);
        drive(1'b1, 7, 1'b0); pulses += out_valid; check("gap_s3", out_sum, 12);
        drive(1'b0, 0, 1'b0); pulses += out_valid; check("gap_s4", out_sum, 12);
        drive(1'b1, 9, 1'b0); pulses += out_valid; check("gap_s5", out_sum, 21);
        check("gap_pulses", pulses, 3);

        // clear priority over simultaneous sample
        drive(1'b0, 0, 1'b1);
        for (int i = 0; i < 5; i++) drive(1'b1, 4, 1'b0);
        check_all("fill20", 20, 2, 1'b1, 1'b0);
        drive(1'b1, 99, 1'b1);
        check_all("clr_with_valid", 0, 0, 1'b0, 1'b0);
        drive(1'b1, 4, 1'b0);
        check_all("after_clr", 4, 0, 1'b1, 1'b0);

        // rounding and eviction
        drive(1'b0, 0, 1'b1);
        drive(1'b1, -1, 1'b0);
        check_all("neg1", -1, -1, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 0, 1'b0);
            check_all($sformatf("zero%0d", i), -1, -1, 1'b1, i == 6);
        end
        drive(1'b1, 0, 1'b0);
        check_all("evicted", 0, 0, 1'b1, 1'b1);
        drive(1'b0, 0, 1'b0);
        check_all("idle_hold", 0, 0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/boxcar_avg_filter.md
BOXCAR_AVG_FILTER -- requirements
Module: boxcar_avg_filter

Interface
REQ-001 Parameter DATA_W, default 8: signed sample width in bits, minimum 2.
REQ-002 Parameter TAPS, default 8: window length in samples; power of two, range 2..256.
REQ-003 Derived constant SUM_W = DATA_W + log2(TAPS): accumulator and out_sum width.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 clr  input  1  synchronous window clear.
REQ-008 in_valid  input  1  in_data carries a sample this cycle.
REQ-009 in_data  input  DATA_W  signed two's-complement sample.
REQ-010 out_valid  output  1  out_sum and out_avg were updated this cycle.
REQ-011 out_sum  output  SUM_W  signed sum of the last TAPS accepted samples.
REQ-012 out_avg  output  DATA_W  signed window average.
REQ-013 out_full  output  1  at least TAPS samples have been accepted since reset or clear.

Function
REQ-014 The delay line SHALL hold TAPS signed DATA_W entries and advance only on an accepted sample (in_valid=1 and clr=0); it SHALL hold when in_valid=0.
REQ-015 On each accepted sample, the accumulator SHALL update to acc + in_data - oldest_entry, where oldest_entry is the entry leaving the window.
REQ-016 The accumulator SHALL be SUM_W bits, sign-extended at the operands, and SHALL never overflow.
REQ-017 Before out_full asserts, empty window slots SHALL count as zero, so out_sum is the sum of the samples received so far.
REQ-018 out_avg SHALL equal out_sum arithmetically right-shifted by log2(TAPS), which rounds toward minus infinity; it is valid before out_full as well.
REQ-019 Latency SHALL be 1 cycle: a sample accepted at edge N produces updated out_sum/out_avg and out_valid=1 after edge N, for one cycle.
REQ-020 out_valid SHALL be 0 in any cycle following an edge with no accepted sample; out_sum/out_avg SHALL hold their last values.
REQ-021 A fill counter SHALL saturate at TAPS; out_full SHALL assert after the edge that accepts the TAPS-th sample and stay high until reset or clr.
REQ-022 Back-to-back samples on every clock SHALL be supported with no bubbles.
REQ-023 When clr=1 at an edge, the block SHALL zero the delay line, accumulator, fill counter, out_sum, out_avg, out_full and out_valid.
REQ-024 clr SHALL take priority over a simultaneous in_valid, and that sample SHALL be discarded.
REQ-025 All outputs SHALL be driven by registers; there is no combinational path from inputs to outputs.

Reset
REQ-026 While rst_n=0, the delay line, accumulator, fill counter, out_valid, out_sum, out_avg and out_full SHALL all be 0, regardless of clk.
REQ-027 rst_n assertion mid-stream SHALL discard the window immediately.
REQ-028 The first accepted sample after rst_n deasserts SHALL yield out_sum = that sample.

Verification (DATA_W=8, TAPS=8)
REQ-029 Reset: assert rst_n=0 between clock edges -> all outputs 0 immediately; after release with in_valid=0 -> outputs remain 0 and out_valid=0.
REQ-030 Step: feed 10 on 9 consecutive cycles -> out_sum 10,20,...,80,80; out_avg 1,2,3,5,6,7,8,10,10; out_full rises with the 8th out_valid.
REQ-031 Extremes: feed -128 x8 -> out_sum -1024, out_avg -128; then feed 127 x8 -> final out_sum 1016, out_avg 127, with no wrap at any step.
REQ-032 Gaps: feed samples 5,_,_,7,_,9, where _ is in_valid=0 -> out_valid pulses exactly 3 times; out_sum 5,12,21 held through the gaps.
REQ-033 Clear: feed 4 x5 (out_sum 20), then clr=1 with in_valid=1 and in_data=99 -> out_sum 0, out_full 0, out_valid 0; next sample 4 -> out_sum 4.
REQ-034 Rounding and eviction: feed -1 once -> out_sum -1, out_avg -1; feed 0 x7 more then 0 once -> out_sum 0 after the -1 is evicted.
